// File: rtl/unit_deploy_scheduler_if.sv
// Purchase request/response bundle between the button front end and the
// deploy scheduler. The requester is the master; the scheduler is the slave.
interface unit_deploy_scheduler_if;
  logic       buy_req;
  logic [1:0] buy_type;
  logic       buy_ack;
  logic       buy_nack;
  logic [1:0] nack_code;

  modport master (output buy_req, buy_type, input buy_ack, buy_nack, nack_code);
  modport slave  (input buy_req, buy_type, output buy_ack, buy_nack, nack_code);
endinterface

// File: rtl/unit_deploy_scheduler.sv
// Deploy scheduler for a bank of unit slots: splits each game tick into a
// damage strobe and a move strobe, owns the gold balance and cooldown, and
// validates/issues purchases to the lowest free slot.
// Optional macro DEPLOY_REFUND_EN: a reservation whose slot is still empty
// four cycles after issue is dropped, its cost refunded and cooldown cleared.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting; dispatches a tick (first) or a buy request
// S_DAMAGE | damage_scen strobe to every slot
// S_MOVE   | move_scen strobe, income added, cooldown decremented
// S_CHECK  | purchase validated (type, free slot, gold, cooldown)
// S_ISSUE  | purchase pulse to the chosen slot, gold charged
module unit_deploy_scheduler #(
  parameter int NUM_UNITS = 4,
  parameter int GOLD_W    = 10,
  parameter int COST1     = 10,
  parameter int COST2     = 20,
  parameter int COST3     = 40,
  parameter int INCOME    = 1,
  parameter int GOLD_MAX  = 999,
  parameter int COOLDOWN  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick_in,
  unit_deploy_scheduler_if.slave buy,
  input  logic [2*NUM_UNITS-1:0] slot_type,
  output logic [NUM_UNITS-1:0]   purchase_out,
  output logic [2:0]             sel_sw,
  output logic                   damage_scen,
  output logic                   move_scen,
  output logic [GOLD_W-1:0]      gold,
  output logic                   busy,
  output logic                   tick_overrun
);

  localparam int CD_W   = $clog2(COOLDOWN + 1);
  localparam int WIDE_W = GOLD_W + $clog2(NUM_UNITS + 2) + 1;

  typedef enum logic [2:0] {S_IDLE, S_DAMAGE, S_MOVE, S_CHECK, S_ISSUE} state_t;

  function automatic logic [GOLD_W-1:0] cost_of(input logic [1:0] t);
    case (t)
      2'b01:   cost_of = GOLD_W'(COST1);
      2'b10:   cost_of = GOLD_W'(COST2);
      2'b11:   cost_of = GOLD_W'(COST3);
      default: cost_of = '0;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [GOLD_W-1:0]     gold_q, gold_d;
  logic [CD_W-1:0]       cd_q, cd_d;
  logic [NUM_UNITS-1:0]  reserved_q, reserved_d;
  logic                  tick_pend_q, tick_pend_d;
  logic                  overrun_q, overrun_d;
  logic                  buy_pend_q, buy_pend_d;
  logic [1:0]            pend_type_q, pend_type_d;
  logic [1:0]            cur_type_q, cur_type_d;
  logic [NUM_UNITS-1:0]  target_q, target_d;
  logic                  nack_late_q, nack_late_d;

  logic [NUM_UNITS-1:0]  occupied, free, pick, expire;
  logic [WIDE_W-1:0]     refund_sum;
  logic [WIDE_W-1:0]     gold_w;
  logic [GOLD_W-1:0]     cost;
  logic                  take_tick_pend, take_live_tick, take_buy_pend, take_live_buy;
  logic                  tick_left, buy_left;
  logic                  check_nack, imm_nack;
  logic [1:0]            check_code;

  // Per-slot occupancy and availability from the unit array's type bits.
  always_comb begin
    occupied = '0;
    free     = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      occupied[i] = |slot_type[2*i +: 2];
      free[i]     = !occupied[i] && !reserved_q[i];
    end
  end

  // Isolate the lowest set bit: lowest-index free slot as a one-hot.
  assign pick = free & (~free + NUM_UNITS'(1));

`ifdef DEPLOY_REFUND_EN
  logic [2:0] age_q   [NUM_UNITS];
  logic [1:0] rtype_q [NUM_UNITS];

  // A reservation expires on its fourth empty cycle after issue.
  always_comb begin
    expire     = '0;
    refund_sum = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      expire[i] = reserved_q[i] && !occupied[i] && (age_q[i] == 3'd3);
      if (expire[i]) refund_sum = refund_sum + WIDE_W'(cost_of(rtype_q[i]));
    end
  end

  // Age and issued type of each reservation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        age_q[i]   <= 3'd0;
        rtype_q[i] <= 2'b00;
      end
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (state_q == S_ISSUE && target_q[i]) begin
          age_q[i]   <= 3'd0;
          rtype_q[i] <= cur_type_q;
        end else if (reserved_q[i] && !occupied[i]) begin
          age_q[i] <= age_q[i] + 3'd1;
        end else begin
          age_q[i] <= 3'd0;
        end
      end
    end
  end
`else
  assign expire     = '0;
  assign refund_sum = '0;
`endif

  // Next-state, strobes, purchase validation and datapath updates.
  always_comb begin
    state_d        = state_q;
    cd_d           = cd_q;
    pend_type_d    = pend_type_q;
    cur_type_d     = cur_type_q;
    target_d       = target_q;
    overrun_d      = overrun_q;
    nack_late_d    = 1'b0;
    damage_scen    = 1'b0;
    move_scen      = 1'b0;
    purchase_out   = '0;
    sel_sw         = 3'b000;
    buy.buy_ack    = 1'b0;
    buy.buy_nack   = 1'b0;
    buy.nack_code  = 2'b00;
    take_tick_pend = 1'b0;
    take_live_tick = 1'b0;
    take_buy_pend  = 1'b0;
    take_live_buy  = 1'b0;
    check_nack     = 1'b0;
    check_code     = 2'b00;
    imm_nack       = 1'b0;
    cost           = cost_of(cur_type_q);
    gold_w         = {{(WIDE_W-GOLD_W){1'b0}}, gold_q};

    case (state_q)
      S_IDLE: begin
        if (tick_pend_q || tick_in) begin
          state_d = S_DAMAGE;
          if (tick_pend_q) take_tick_pend = 1'b1;
          else             take_live_tick = 1'b1;
        end else if (buy_pend_q || buy.buy_req) begin
          state_d = S_CHECK;
          if (buy_pend_q) take_buy_pend = 1'b1;
          else            take_live_buy = 1'b1;
        end
      end
      S_DAMAGE: begin
        damage_scen = 1'b1;
        state_d     = S_MOVE;
      end
      S_MOVE: begin
        // Leaving the move phase dispatches straight from the pending
        // flags so a waiting buy is checked on the very next cycle.
        move_scen = 1'b1;
        if (tick_pend_q) begin
          state_d        = S_DAMAGE;
          take_tick_pend = 1'b1;
        end else if (buy_pend_q) begin
          state_d       = S_CHECK;
          take_buy_pend = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (cur_type_q == 2'b00) begin
          check_nack = 1'b1;
          check_code = 2'b00;
        end else if (!(|free)) begin
          check_nack = 1'b1;
          check_code = 2'b01;
        end else if (gold_q < cost) begin
          check_nack = 1'b1;
          check_code = 2'b10;
        end else if (cd_q != '0) begin
          check_nack = 1'b1;
          check_code = 2'b11;
        end
        if (check_nack) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_ISSUE;
          target_d = pick;
        end
      end
      S_ISSUE: begin
        purchase_out = target_q;
        buy.buy_ack  = 1'b1;
        case (cur_type_q)
          2'b01:   sel_sw = 3'b100;
          2'b10:   sel_sw = 3'b010;
          2'b11:   sel_sw = 3'b001;
          default: sel_sw = 3'b000;
        endcase
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (take_buy_pend) cur_type_d = pend_type_q;
    if (take_live_buy) cur_type_d = buy.buy_type;

    // A tick that cannot be taken or parked overflows the single pending slot.
    tick_left   = tick_pend_q && !take_tick_pend;
    tick_pend_d = tick_left;
    if (tick_in && !take_live_tick) begin
      if (tick_left) overrun_d   = 1'b1;
      else           tick_pend_d = 1'b1;
    end

    buy_left   = buy_pend_q && !take_buy_pend;
    buy_pend_d = buy_left;
    if (buy.buy_req && !take_live_buy) begin
      if (buy_left) begin
        imm_nack = 1'b1;
      end else begin
        buy_pend_d  = 1'b1;
        pend_type_d = buy.buy_type;
      end
    end

    // A busy-reject colliding with a check-reject is reported one cycle late.
    if (check_nack) begin
      buy.buy_nack  = 1'b1;
      buy.nack_code = check_code;
      nack_late_d   = imm_nack;
    end else if (imm_nack || nack_late_q) begin
      buy.buy_nack  = 1'b1;
      buy.nack_code = 2'b01;
    end

    if (state_q == S_MOVE) gold_w = gold_w + WIDE_W'(INCOME);
    gold_w = gold_w + refund_sum;
    if (gold_w > WIDE_W'(GOLD_MAX)) gold_w = WIDE_W'(GOLD_MAX);
    gold_d = gold_w[GOLD_W-1:0];
    if (state_q == S_ISSUE) gold_d = gold_d - cost;

    if (state_q == S_MOVE && cd_q != '0) cd_d = cd_q - CD_W'(1);
    if (|expire) cd_d = '0;
    if (state_q == S_ISSUE) cd_d = CD_W'(COOLDOWN);

    reserved_d = reserved_q & ~occupied & ~expire;
    if (state_q == S_ISSUE) reserved_d = reserved_d | target_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      gold_q      <= GOLD_W'(GOLD_MAX);
      cd_q        <= '0;
      reserved_q  <= '0;
      tick_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      buy_pend_q  <= 1'b0;
      pend_type_q <= 2'b00;
      cur_type_q  <= 2'b00;
      target_q    <= '0;
      nack_late_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gold_q      <= gold_d;
      cd_q        <= cd_d;
      reserved_q  <= reserved_d;
      tick_pend_q <= tick_pend_d;
      overrun_q   <= overrun_d;
      buy_pend_q  <= buy_pend_d;
      pend_type_q <= pend_type_d;
      cur_type_q  <= cur_type_d;
      target_q    <= target_d;
      nack_late_q <= nack_late_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign gold         = gold_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_unit_deploy_scheduler.sv
// Scoreboard bench for unit_deploy_scheduler: stimulus pushes the expected
// strobe/ack/nack events, a negedge monitor pops and compares them.
module tb_unit_deploy_scheduler;
  localparam int EV_DAMAGE = 0;
  localparam int EV_MOVE   = 1;
  localparam int EV_ACK    = 2;
  localparam int EV_NACK   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_in = 1'b0;
  logic [7:0] slot_type = 8'h00;
  logic [3:0] purchase_out;
  logic [2:0] sel_sw;
  logic       damage_scen, move_scen, busy, tick_overrun;
  logic [9:0] gold;

  unit_deploy_scheduler_if bif ();

  unit_deploy_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .tick_in      (tick_in),
    .buy          (bif),
    .slot_type    (slot_type),
    .purchase_out (purchase_out),
    .sel_sw       (sel_sw),
    .damage_scen  (damage_scen),
    .move_scen    (move_scen),
    .gold         (gold),
    .busy         (busy),
    .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [3:0] po;
    logic [2:0] sel;
    logic [1:0] code;
    int         gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_ev = 0;
  int   gold_m = 999;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic handle(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event kind=%0d actual=present required=none (cycle %0d)", kind, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.gap >= 0) chk("event_gap", cyc - last_ev, e.gap);
      if (kind == EV_ACK) begin
        chk("purchase_out", purchase_out, e.po);
        chk("sel_sw", sel_sw, e.sel);
      end
      if (kind == EV_NACK) chk("nack_code", bif.nack_code, e.code);
    end
    last_ev = cyc;
  endtask

  // Monitor: every strobe/ack/nack must match the next expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (damage_scen) begin
          chk("strobe_overlap", move_scen, 0);
          handle(EV_DAMAGE);
        end
        if (move_scen) handle(EV_MOVE);
        if (bif.buy_ack) handle(EV_ACK);
        if (bif.buy_nack) handle(EV_NACK);
        if (!bif.buy_ack && purchase_out != 4'b0000) chk("stray_purchase", purchase_out, 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic int cost(input logic [1:0] t);
    case (t)
      2'b01:   return 10;
      2'b10:   return 20;
      2'b11:   return 40;
      default: return 0;
    endcase
  endfunction

  task automatic push(input int kind, input logic [3:0] po, input logic [2:0] sel,
                      input logic [1:0] code, input int gap);
    exp_t e;
    e.kind = kind; e.po = po; e.sel = sel; e.code = code; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic set_in(input logic t, input logic b, input logic [1:0] ty);
    @(posedge clk);
    #1;
    tick_in      = t;
    bif.buy_req  = b;
    bif.buy_type = ty;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 2'b00);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((busy || q.size() != 0) && n < 200);
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_done actual=busy_or_%0d_pending required=idle", q.size());
      q.delete();
    end
  endtask

  task automatic do_tick();
    push(EV_DAMAGE, 4'b0, 3'b0, 2'b0, -1);
    push(EV_MOVE, 4'b0, 3'b0, 2'b0, 1);
    set_in(1'b1, 1'b0, 2'b00);
    idle_in();
    wait_done();
    gold_m = (gold_m + 1 > 999) ? 999 : gold_m + 1;
  endtask

  task automatic do_buy(input logic [1:0] ty, input int kind, input logic [3:0] po,
                        input logic [2:0] sel, input logic [1:0] code);
    push(kind, po, sel, code, -1);
    set_in(1'b0, 1'b1, ty);
    idle_in();
    wait_done();
    if (kind == EV_ACK) gold_m = gold_m - cost(ty);
  endtask

  initial begin
    int busy_cnt;
    bif.buy_req  = 1'b0;
    bif.buy_type = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_gold", gold, 999);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", tick_overrun, 0);
    chk("rst_purchase", purchase_out, 0);
    chk("rst_sel", sel_sw, 0);
    chk("rst_strobes", {damage_scen, move_scen}, 0);
    chk("rst_acknack", {bif.buy_ack, bif.buy_nack}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single tick: damage then move, busy for two cycles, gold saturated.
    push(EV_DAMAGE, 4'b0, 3'b0, 2'b0, -1);
    push(EV_MOVE, 4'b0, 3'b0, 2'b0, 1);
    set_in(1'b1, 1'b0, 2'b00);
    idle_in();
    busy_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("busy_cycles", busy_cnt, 2);
    wait_done();
    chk("tick_gold_sat", gold, 999);

`ifdef DEPLOY_REFUND_EN
    // Unclaimed reservation: refund after four cycles, same slot reusable.
    do_buy(2'b01, EV_ACK, 4'b0001, 3'b100, 2'b00);
    chk("refund_charged", gold, 989);
    repeat (6) @(negedge clk);
    chk("refund_restored", gold, 999);
    do_buy(2'b01, EV_ACK, 4'b0001, 3'b100, 2'b00);
    slot_type = 8'h01;
    repeat (8) @(negedge clk);
    chk("deployed_no_refund", gold, 989);
    slot_type = 8'h00;
`else
    // First purchase on an all-free bank, then a cooldown reject.
    do_buy(2'b10, EV_ACK, 4'b0001, 3'b010, 2'b00);
    chk("buy10_gold", gold, 979);
    do_buy(2'b10, EV_NACK, 4'b0, 3'b0, 2'b11);
    chk("cooldown_gold", gold, 979);

    // Slots 0,1 occupied -> slot 2; all occupied -> no free slot.
    repeat (8) do_tick();
    chk("ticks_gold", gold, 987);
    slot_type = 8'b00_00_01_10;
    do_buy(2'b01, EV_ACK, 4'b0100, 3'b100, 2'b00);
    chk("buy01_gold", gold, 977);
    slot_type = 8'b01_01_01_01;
    do_buy(2'b11, EV_NACK, 4'b0, 3'b0, 2'b01);
    chk("nofree_gold", gold, 977);

    // Drain gold with type-11 purchases, deploying each unit right away.
    slot_type = 8'h00;
    for (int it = 0; it < 40; it++) begin
      repeat (8) do_tick();
      if (gold_m < 40) break;
      do_buy(2'b11, EV_ACK, 4'b0001, 3'b001, 2'b00);
      @(posedge clk); #1 slot_type = 8'h03;
      @(posedge clk); #1 slot_type = 8'h00;
    end
    chk("drain_gold", gold, 25);
    repeat (5) do_tick();
    chk("gold_30", gold, 30);
    do_buy(2'b11, EV_NACK, 4'b0, 3'b0, 2'b10);
    chk("poor_gold", gold, 30);
    do_buy(2'b00, EV_NACK, 4'b0, 3'b0, 2'b00);
    do_buy(2'b10, EV_ACK, 4'b0001, 3'b010, 2'b00);
    chk("buy10b_gold", gold, 10);

    // Cooldown boundary: 7 ticks still blocked, 8th releases; slot 0 reserved.
    repeat (7) do_tick();
    do_buy(2'b01, EV_NACK, 4'b0, 3'b0, 2'b11);
    do_tick();
    do_buy(2'b01, EV_ACK, 4'b0010, 3'b100, 2'b00);
    chk("reserved_gold", gold, 8);

    // Tick and buy together: purchase two cycles after move.
    repeat (8) do_tick();
    push(EV_DAMAGE, 4'b0, 3'b0, 2'b0, -1);
    push(EV_MOVE, 4'b0, 3'b0, 2'b0, 1);
    push(EV_ACK, 4'b0100, 3'b100, 2'b0, 2);
    set_in(1'b1, 1'b1, 2'b01);
    idle_in();
    wait_done();
    chk("tickbuy_gold", gold, 7);

    // Two ticks while busy: one serviced, overrun sticky.
    repeat (8) do_tick();
    push(EV_ACK, 4'b1000, 3'b100, 2'b0, -1);
    push(EV_DAMAGE, 4'b0, 3'b0, 2'b0, 2);
    push(EV_MOVE, 4'b0, 3'b0, 2'b0, 1);
    set_in(1'b0, 1'b1, 2'b01);
    set_in(1'b1, 1'b0, 2'b00);
    set_in(1'b1, 1'b0, 2'b00);
    idle_in();
    wait_done();
    chk("overrun_flag", tick_overrun, 1);
    chk("overrun_gold", gold, 6);

    // Second buy while one is pending: immediate reject, then gold reject.
    @(posedge clk); #1 slot_type = 8'b01_01_01_01;
    @(posedge clk); #1 slot_type = 8'h00;
    push(EV_DAMAGE, 4'b0, 3'b0, 2'b0, -1);
    push(EV_NACK, 4'b0, 3'b0, 2'b01, 0);
    push(EV_MOVE, 4'b0, 3'b0, 2'b0, 1);
    push(EV_NACK, 4'b0, 3'b0, 2'b10, 1);
    set_in(1'b1, 1'b1, 2'b01);
    set_in(1'b0, 1'b1, 2'b11);
    idle_in();
    wait_done();
    chk("busy_nack_gold", gold, 7);
`endif

    repeat (6) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("final_busy", busy, 0);
`ifndef DEPLOY_REFUND_EN
    chk("overrun_sticky", tick_overrun, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unit_deploy_scheduler.md
Name: unit_deploy_scheduler

Overview:
- Controller for a bank of NUM_UNITS player unit slots.
- Sequences each game tick into a damage strobe followed by a move strobe, which drive every slot's damageSCEN/moveSCEN.
- Owns the gold balance and validates purchase requests against type, free slot, cost and cooldown.
- Issues a one-hot purchase pulse plus the type-select switches to the lowest free slot. Sits between the button/switch inputs and the unit array in the top level.

Parameters:
- NUM_UNITS, 4, number of unit slots managed.
- GOLD_W, 10, gold counter width.
- COST1, 10, cost of type 01.
- COST2, 20, cost of type 10.
- COST3, 40, cost of type 11.
- INCOME, 1, gold added per tick.
- GOLD_MAX, 999, saturation ceiling; also the reset balance.
- COOLDOWN, 8, ticks between successful purchases.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick_in  in  1  one-cycle game-tick pulse (clk domain).
- buy_req  in  1  one-cycle purchase request pulse.
- buy_type  in  2  requested type; 00 is invalid.
- slot_type  in  2*NUM_UNITS  unitType of each slot; slot i occupies bits [2i+1:2i]; 00 = free.
- purchase_out  out  NUM_UNITS  one-hot purchase pulse to a slot.
- sel_sw  out  3  {SW1,SW2,SW3} one-hot type select; valid in the purchase_out cycle.
- damage_scen  out  1  damage-phase strobe to all slots.
- move_scen  out  1  move-phase strobe to all slots.
- gold  out  GOLD_W  current balance.
- buy_ack  out  1  one-cycle pulse: purchase accepted.
- buy_nack  out  1  one-cycle pulse: purchase rejected.
- nack_code  out  2  rejection reason, valid with buy_nack.
- busy  out  1  high whenever the FSM is not in S_IDLE.
- tick_overrun  out  1  sticky flag: a tick was dropped.

Behaviour:
- Reset values (reset low):
  - state S_IDLE.
  - gold = GOLD_MAX; cooldown counter = 0.
  - reserved mask = 0; pending tick and pending buy flags = 0.
  - tick_overrun = 0.
  - All other outputs 0.
- Reset mid-sequence aborts any phase. No strobe or purchase pulse is emitted after reset asserts.
- FSM states: S_IDLE, S_DAMAGE, S_MOVE, S_CHECK, S_ISSUE.
- Tick sequence:
  - S_IDLE with a tick (live or pending) goes to S_DAMAGE.
  - S_DAMAGE: damage_scen=1 for exactly one cycle, then S_MOVE.
  - S_MOVE: move_scen=1 for exactly one cycle. In the same cycle, gold = min(gold+INCOME, GOLD_MAX) and cooldown decrements if nonzero. Then S_IDLE.
  - Result: damage_scen and move_scen are never high in the same cycle; move_scen always follows damage_scen by exactly 1 cycle.
- Priority in S_IDLE: a tick beats a buy. If tick_in and buy_req arrive together, buy_type is latched into the pending buy and served after the tick sequence.
- Events arriving while busy:
  - tick_in sets the pending tick flag.
  - A tick arriving while a tick is already pending is dropped and sets tick_overrun. tick_overrun clears only on reset.
  - buy_req while busy is latched if no buy is pending. Otherwise it is rejected immediately with buy_nack and nack_code=01.
- S_CHECK (1 cycle) evaluates the request in priority order:
  - buy_type == 00: code 00, reject.
  - No slot with slot_type==00 and reserved==0: code 01, reject.
  - gold < cost: code 10, reject.
  - cooldown != 0: code 11, reject.
  - A reject pulses buy_nack with its code and returns to S_IDLE. A pass goes to S_ISSUE.
- S_ISSUE (1 cycle):
  - Targets the lowest-index free slot: purchase_out bit high, sel_sw = 100/010/001 for type 01/10/11.
  - gold -= cost; cooldown = COOLDOWN; reserved[slot]=1; buy_ack=1.
  - Then S_IDLE.
- A reserved bit clears when that slot's slot_type becomes nonzero. A slot whose type later returns to 00 (unit died) is free again.
- Gold arithmetic is unsigned and saturating. A purchase never drives gold negative, because of the check.

Optional Feature:
- Macro DEPLOY_REFUND_EN.
- Defined:
  - Each reserved slot has a 3-bit age counter.
  - If slot_type is still 00 four cycles after issue, the reservation clears and the cost of the issued type is refunded (saturating at GOLD_MAX).
  - The cooldown is also cleared.
- Undefined: no timeout. Reservations clear only on deploy or reset.

Test Plan:
- Reset low then high, single tick_in -> damage_scen high 1 cycle, move_scen high the next cycle, gold stays 999 (saturated), busy high 2 cycles.
- All slots free, gold=999, buy_req with type 10 -> purchase_out=0001, sel_sw=010, buy_ack, gold=979, cooldown=8; a second buy before 8 ticks -> buy_nack, code 11.
- slot_type for slots 0 and 1 nonzero, buy type 01 -> purchase_out=0100. All four slots nonzero -> buy_nack, code 01.
- Gold reduced to 30, buy type 11 -> buy_nack, code 10, gold unchanged. buy_type 00 -> code 00.
- tick_in and buy_req in the same cycle -> damage, move, then S_CHECK; purchase issued 2 cycles after move_scen. Two more ticks while busy -> one serviced, tick_overrun=1.
- DEPLOY_REFUND_EN defined, slot_type held 00 after a type-01 purchase -> after 4 cycles, gold restored by 10, reserved cleared, next buy targets the same slot.
